shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 120 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier producing a 2*width-bit product.
// One partial product is accumulated per clock while in RUN. The done pulse is
// meant to drive the enable of a downstream Barrett reducer.
// Optional feature: define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. Without it, every operation takes
// exactly width RUN cycles.
module shift_add_multiplier #(
    parameter int width = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*width-1:0]   ab
);

    localparam int cnt_w = $clog2(width + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*width-1:0] mcand;
    logic [2*width-1:0] acc;
    logic [2*width-1:0] sum;
    logic [width-1:0]   mplier;
    logic [width-1:0]   mplier_shift;
    logic [cnt_w-1:0]   count;
    logic               last_step;

    // Partial-product add, multiplier shift and completion detect for this RUN cycle
    always_comb begin
        sum          = acc;
        mplier_shift = mplier >> 1;
        last_step    = (count == cnt_w'(width - 1));
        if (mplier[0]) begin
            sum = acc + mcand;
        end
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        if (mplier_shift == '0) begin
            last_step = 1'b1;
        end
`endif
    end

    // Next-state and busy decode; enable is only looked at while idle
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, accumulate/shift datapath and registered product/done
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            ab     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        mcand  <= {{width{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shift;
                    count  <= count + cnt_w'(1);
                    if (last_step) begin
                        ab   <= sum;
                        done <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at width=8, using directed
// scenarios plus randomized operands against an arithmetic reference model.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           enable;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] ab;

    int pass_count  = 0;
    int check_count = 0;

    shift_add_multiplier #(.width(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .ab     (ab)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference latency in RUN cycles from the start edge to the completion edge
    function automatic int ref_latency(input logic [W-1:0] bv);
        int hi;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        hi = -1;
        for (int i = 0; i < W; i++) begin
            if (bv[i]) hi = i;
        end
        return (hi < 0) ? 1 : hi + 1;
`else
        hi = bv;
        return W;
`endif
    endfunction

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with enable for exactly one edge (edge S)
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        a      = av;
        b      = bv;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Count edges after S until done is observed; -1 if the bound expires
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check_count++;
        if ({busy, done, ab} !== '0) $display("[TB] FAIL reset_state: busy=%0b done=%0b ab=%0d, want 0/0/0", busy, done, ab);
        else pass_count++;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_count++;
            if ({busy, done, ab} !== '0) $display("[TB] FAIL reset_idle_%0d: busy=%0b done=%0b ab=%0d, want 0/0/0", i, busy, done, ab);
            else pass_count++;
        end
    endtask

    task automatic test_basic();
        int cyc;
        start_op(8'd13, 8'd11);
        check_count++;
        if (busy !== 1'b1) $display("[TB] FAIL basic_busy: busy=%0b, want 1", busy);
        else pass_count++;
        wait_done(W + 4, cyc);
        check_count++;
        if (cyc != ref_latency(8'd11)) $display("[TB] FAIL basic_latency: got %0d, want %0d", cyc, ref_latency(8'd11));
        else pass_count++;
        check_count++;
        if (ab !== 16'd143) $display("[TB] FAIL basic_ab: got %0d, want 143", ab);
        else pass_count++;
        tick();
        check_count++;
        if (done !== 1'b0 || busy !== 1'b0 || ab !== 16'd143)
            $display("[TB] FAIL basic_after: done=%0b busy=%0b ab=%0d, want 0/0/143", done, busy, ab);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(8'd255, 8'd255);
        wait_done(W + 4, cyc);
        check_count++;
        if (cyc != W || ab !== 16'd65025)
            $display("[TB] FAIL b2b_first: latency=%0d ab=%0d, want %0d/65025", cyc, ab, W);
        else pass_count++;
        start_op(8'd0, 8'd7);
        wait_done(W + 4, cyc);
        check_count++;
        if (cyc < 0 || cyc + 1 != 1 + ref_latency(8'd7))
            $display("[TB] FAIL b2b_spacing: got %0d, want %0d", cyc + 1, 1 + ref_latency(8'd7));
        else pass_count++;
        check_count++;
        if (ab !== 16'd0) $display("[TB] FAIL b2b_second_ab: got %0d, want 0", ab);
        else pass_count++;
        tick();
    endtask

    task automatic test_ignore_enable();
        int dones;
        logic [2*W-1:0] seen_ab;
        dones   = 0;
        seen_ab = '0;
        start_op(8'd3, 8'd5);
        for (int k = 1; k <= W + 6; k++) begin
            tick();
            if (done) begin
                dones++;
                seen_ab = ab;
            end
            if (k == 2) begin
                enable = 1'b1;
                a      = 8'd99;
                b      = 8'd99;
            end else begin
                enable = 1'b0;
            end
        end
        check_count++;
        if (dones != 1) $display("[TB] FAIL ignore_done_count: got %0d, want 1", dones);
        else pass_count++;
        check_count++;
        if (seen_ab !== 16'd15) $display("[TB] FAIL ignore_ab: got %0d, want 15", seen_ab);
        else pass_count++;
    endtask

    task automatic test_abort();
        int cyc;
        logic saw_done;
        saw_done = 1'b0;
        start_op(8'd200, 8'd200);
        for (int k = 1; k <= 3; k++) begin
            tick();
            saw_done |= done;
        end
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check_count++;
        if (busy !== 1'b0 || done !== 1'b0 || ab !== 16'd0 || saw_done)
            $display("[TB] FAIL abort_state: busy=%0b done=%0b ab=%0d early_done=%0b, want 0/0/0/0", busy, done, ab, saw_done);
        else pass_count++;
        tick();
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL abort_enable_in_reset: busy=%0b, want 0", busy);
        else pass_count++;
        enable = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            saw_done |= done | busy;
        end
        check_count++;
        if (saw_done) $display("[TB] FAIL abort_quiet: activity=1, want 0");
        else pass_count++;
        start_op(8'd200, 8'd3);
        wait_done(W + 4, cyc);
        check_count++;
        if (cyc != ref_latency(8'd3) || ab !== 16'd600)
            $display("[TB] FAIL abort_restart: latency=%0d ab=%0d, want %0d/600", cyc, ab, ref_latency(8'd3));
        else pass_count++;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0]   av;
        logic [W-1:0]   bv;
        logic [2*W-1:0] prev;
        int             cyc;
        logic           held;
        for (int n = 0; n < 30; n++) begin
            av   = W'($urandom);
            bv   = W'($urandom);
            if (n == 0) bv = '0;
            prev = ab;
            held = 1'b1;
            cyc  = -1;
            start_op(av, bv);
            for (int k = 1; k <= W + 3; k++) begin
                tick();
                if (done) begin
                    cyc    = k;
                    enable = 1'b0;
                    break;
                end
                if (ab !== prev) held = 1'b0;
                enable = 1'($urandom);
                a      = W'($urandom);
                b      = W'($urandom);
            end
            enable = 1'b0;
            check_count++;
            if (!held) $display("[TB] FAIL rand_hold_%0d: ab changed before completion, want %0d", n, prev);
            else pass_count++;
            check_count++;
            if (cyc != ref_latency(bv)) $display("[TB] FAIL rand_latency_%0d: got %0d, want %0d", n, cyc, ref_latency(bv));
            else pass_count++;
            check_count++;
            if (ab !== av * bv) $display("[TB] FAIL rand_ab_%0d: got %0d, want %0d", n, ab, av * bv);
            else pass_count++;
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_enable();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
